// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, request kinds and loader FSM states.
// The control decoder uses the same opcode/funct values.
package mips_pkg;

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [OP_W-1:0] F_ADD = 6'b100000;
   localparam logic [OP_W-1:0] F_SUB = 6'b100010;
   localparam logic [OP_W-1:0] F_AND = 6'b100100;
   localparam logic [OP_W-1:0] F_OR  = 6'b100101;
   localparam logic [OP_W-1:0] F_SLT = 6'b101010;

   typedef enum logic [3:0] {
      K_ADD  = 4'd0,
      K_SUB  = 4'd1,
      K_AND  = 4'd2,
      K_OR   = 4'd3,
      K_SLT  = 4'd4,
      K_LW   = 4'd5,
      K_SW   = 4'd6,
      K_BEQ  = 4'd7,
      K_ADDI = 4'd8,
      K_J    = 4'd9
   } kind_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      kind_e       kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_req_t;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Request handshake and imem write port of the program loader.
interface instr_encode_loader_if #(
   parameter int unsigned AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_kind;
   logic [4:0]    req_rs;
   logic [4:0]    req_rt;
   logic [4:0]    req_rd;
   logic [15:0]   req_imm;
   logic [25:0]   req_target;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   modport master (
      output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, req_target,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic request -> 32-bit MIPS word plus legality flag.
module instr_encode
   import mips_pkg::*;
(
   input  instr_req_t  req,
   output logic [31:0] word_c,
   output logic        legal_c
);

   always_comb begin
      word_c  = '0;
      legal_c = 1'b1;
      case (req.kind)
         K_ADD:   word_c = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, F_ADD};
         K_SUB:   word_c = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, F_SUB};
         K_AND:   word_c = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, F_AND};
         K_OR:    word_c = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, F_OR};
         K_SLT:   word_c = {OP_RTYPE, req.rs, req.rt, req.rd, 5'd0, F_SLT};
         K_LW:    word_c = {OP_LW,    req.rs, req.rt, req.imm};
         K_SW:    word_c = {OP_SW,    req.rs, req.rt, req.imm};
         K_BEQ:   word_c = {OP_BEQ,   req.rs, req.rt, req.imm};
         K_ADDI:  word_c = {OP_ADDI,  req.rs, req.rt, req.imm};
         K_J:     word_c = {OP_J,     req.target};
         default: legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts symbolic requests, encodes them and writes
// consecutive imem words with a one-cycle registered write stage.
module instr_encode_loader
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [AW-1:0]                base_addr,
   input  logic                         finish,
   instr_encode_loader_if.slave         bus,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         busy,
   output logic                         done,
   output logic                         err_kind,
   output logic                         err_full
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   state_e        state, state_nx;
   logic          fin, fin_nx;
   logic [AW-1:0] waddr, waddr_nx;
   logic [AW-1:0] addr_nx;
   logic [31:0]   wdata_nx;
   logic [CW-1:0] count_nx;
   logic          we_nx, ready_nx, errk_nx, errf_nx;
   logic          full_c, accept_c;
   instr_req_t    req_c;
   logic [31:0]   word_c;
   logic          legal_c;

   always_comb begin
      req_c.kind   = kind_e'(bus.req_kind);
      req_c.rs     = bus.req_rs;
      req_c.rt     = bus.req_rt;
      req_c.rd     = bus.req_rd;
      req_c.imm    = bus.req_imm;
      req_c.target = bus.req_target;
   end

   instr_encode u_encode (
      .req     (req_c),
      .word_c  (word_c),
      .legal_c (legal_c)
   );

   // Words written plus the one in the write stage; reaching DEPTH blocks acceptance.
   assign full_c = ((CW+1)'(count) + (CW+1)'(bus.imem_we)) == (CW+1)'(DEPTH);

   always_comb begin
      state_nx = state;
      fin_nx   = fin;
      waddr_nx = waddr;
      addr_nx  = bus.imem_addr;
      wdata_nx = bus.imem_wdata;
      count_nx = count;
      we_nx    = 1'b0;
      errk_nx  = err_kind;
      errf_nx  = err_full;
      accept_c = 1'b0;

      if (bus.imem_we && (count != CW'(DEPTH)))
         count_nx = count + CW'(1);

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nx = S_LOAD;
               fin_nx   = 1'b0;
               waddr_nx = base_addr & ~AW'(3);
               count_nx = '0;
               errk_nx  = 1'b0;
               errf_nx  = 1'b0;
            end
         end
         S_LOAD: begin
            accept_c = bus.req_valid && bus.req_ready;
            if (bus.req_valid && full_c)
               errf_nx = 1'b1;
            if (accept_c) begin
               if (legal_c) begin
                  we_nx    = 1'b1;
                  addr_nx  = waddr;
                  wdata_nx = word_c;
                  waddr_nx = waddr + AW'(4);
               end else begin
                  errk_nx = 1'b1;
               end
            end
            if (finish)
               fin_nx = 1'b1;
            // Leave only once the final accepted word is in the write stage or done.
            if ((finish || fin) && !we_nx) begin
               state_nx = S_DONE;
               fin_nx   = 1'b0;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      ready_nx = (state_nx == S_LOAD) && !fin_nx &&
                 (((CW+1)'(count_nx) + (CW+1)'(we_nx)) != (CW+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         fin            <= 1'b0;
         waddr          <= '0;
         bus.req_ready  <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         count          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_kind       <= 1'b0;
         err_full       <= 1'b0;
      end else begin
         state          <= state_nx;
         fin            <= fin_nx;
         waddr          <= waddr_nx;
         bus.req_ready  <= ready_nx;
         bus.imem_we    <= we_nx;
         bus.imem_addr  <= addr_nx;
         bus.imem_wdata <= wdata_nx;
         count          <= count_nx;
         busy           <= (state_nx == S_LOAD);
         done           <= (state_nx == S_DONE);
         err_kind       <= errk_nx;
         err_full       <= errf_nx;
      end
   end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with a 4-word session depth.
module tb_instr_encode_loader;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] base_addr;
   logic        finish;
   logic [2:0]  count;
   logic        busy, done, err_kind, err_full;

   int pass  = 0;
   int total = 0;
   int wr_cnt = 0;

   instr_encode_loader_if #(.AW(AW)) bus ();

   instr_encode_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .finish    (finish),
      .bus       (bus),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .err_kind  (err_kind),
      .err_full  (err_full)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.imem_we === 1'b1) wr_cnt++;

   // Reference control decode: {branch, jump, alusrc}
   function automatic logic [2:0] ctrl(input logic [31:0] w);
      logic [5:0] op;
      op = w[31:26];
      return {op == 6'b000100, op == 6'b000010,
              (op == 6'b100011) || (op == 6'b101011) || (op == 6'b001000)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
      bus.req_valid  = 1'b1;
      bus.req_kind   = k;
      bus.req_rs     = rs;
      bus.req_rt     = rt;
      bus.req_rd     = rd;
      bus.req_imm    = imm;
      bus.req_target = tg;
   endtask

   task automatic begin_session(input logic [31:0] base);
      base_addr = base;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic end_session();
      bus.req_valid = 1'b0;
      finish = 1'b1;
      step();
      finish = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++; if ({bus.req_ready, bus.imem_we, busy, done, err_kind, err_full} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000",
                  {bus.req_ready, bus.imem_we, busy, done, err_kind, err_full}); else pass++;
      total++; if (bus.imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.imem_addr); else pass++;
      total++; if (bus.imem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.imem_wdata); else pass++;
      total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else pass++;
      rst = 1'b0;
   endtask

   task automatic test_start_encode();
      begin_session(32'h0000_0042);
      total++; if ({busy, bus.req_ready} !== 2'b11) $display("FAIL start_busy_ready: got %b want 11", {busy, bus.req_ready}); else pass++;
      req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      step();
      total++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 32'h40, 32'h0022_1820})
         $display("FAIL add_write: got we=%b addr=%h data=%h want we=1 addr=00000040 data=00221820",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata); else pass++;
      req(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0);
      step();
      total++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 32'h44, 32'h8C08_0004})
         $display("FAIL lw_write: got we=%b addr=%h data=%h want we=1 addr=00000044 data=8c080004",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata); else pass++;
      bus.req_valid = 1'b0;
      step();
      total++; if (count !== 3'd2) $display("FAIL count_two: got %0d want 2", count); else pass++;
      total++; if ({bus.imem_we, bus.imem_addr} !== {1'b0, 32'h44}) $display("FAIL addr_hold: got we=%b addr=%h want we=0 addr=00000044", bus.imem_we, bus.imem_addr); else pass++;
      end_session();
      total++; if ({done, busy} !== 2'b10) $display("FAIL finish_done: got done,busy=%b want 10", {done, busy}); else pass++;
   endtask

   task automatic test_itype_wrap();
      begin_session(32'hFFFF_FFF8);
      req(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
      step();
      total++; if ({bus.imem_addr, bus.imem_wdata} !== {32'hFFFF_FFF8, 32'h1022_FFFF}) $display("FAIL beq_write: got %h %h want fffffff8 1022ffff", bus.imem_addr, bus.imem_wdata); else pass++;
      total++; if (ctrl(bus.imem_wdata) !== 3'b100) $display("FAIL beq_branch: got %b want 100", ctrl(bus.imem_wdata)); else pass++;
      req(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
      step();
      total++; if ({bus.imem_addr, bus.imem_wdata} !== {32'hFFFF_FFFC, 32'h0800_0010}) $display("FAIL j_write: got %h %h want fffffffc 08000010", bus.imem_addr, bus.imem_wdata); else pass++;
      total++; if (ctrl(bus.imem_wdata) !== 3'b010) $display("FAIL j_jump: got %b want 010", ctrl(bus.imem_wdata)); else pass++;
      req(4'd8, 5'd0, 5'd9, 5'd0, 16'h0005, 26'h0);
      step();
      total++; if ({bus.imem_addr, bus.imem_wdata} !== {32'h0, 32'h2009_0005}) $display("FAIL addi_wrap: got %h %h want 00000000 20090005", bus.imem_addr, bus.imem_wdata); else pass++;
      total++; if (ctrl(bus.imem_wdata) !== 3'b001) $display("FAIL addi_alusrc: got %b want 001", ctrl(bus.imem_wdata)); else pass++;
      req(4'd6, 5'd29, 5'd31, 5'd0, 16'h0008, 26'h0);
      step();
      total++; if ({bus.imem_addr, bus.imem_wdata} !== {32'h4, 32'hAFBF_0008}) $display("FAIL sw_write: got %h %h want 00000004 afbf0008", bus.imem_addr, bus.imem_wdata); else pass++;
      total++; if (bus.req_ready !== 1'b0) $display("FAIL ready_at_depth: got %b want 0", bus.req_ready); else pass++;
      bus.req_valid = 1'b0;
      step();
      total++; if (count !== 3'd4) $display("FAIL count_depth: got %0d want 4", count); else pass++;
      end_session();
   endtask

   task automatic test_rtype();
      logic [3:0]  kinds [4];
      logic [31:0] words [4];
      kinds = '{4'd1, 4'd2, 4'd3, 4'd4};
      words = '{32'h0085_3022, 32'h0085_3024, 32'h0085_3025, 32'h0085_302A};
      begin_session(32'h0000_0200);
      for (int i = 0; i < 4; i++) begin
         req(kinds[i], 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
         step();
         total++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 32'h200 + 32'(4*i), words[i]})
            $display("FAIL rtype_%0d: got we=%b addr=%h data=%h want addr=%h data=%h", i,
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, 32'h200 + 32'(4*i), words[i]); else pass++;
      end
      end_session();
      total++; if ({done, count} !== {1'b1, 3'd4}) $display("FAIL rtype_done: got done=%b count=%0d want done=1 count=4", done, count); else pass++;
   endtask

   task automatic test_back_to_back_full();
      int  wr0;
      logic r;
      begin_session(32'h0);
      wr0 = wr_cnt;
      for (int i = 0; i < 6; i++) begin
         req(4'd8, 5'd0, 5'(i+1), 5'd0, 16'(i+1), 26'h0);
         r = bus.req_ready;
         step();
         total++; if (r !== (i < 4)) $display("FAIL full_ready_%0d: got %b want %b", i, r, (i < 4)); else pass++;
         total++; if (bus.imem_we !== (i < 4)) $display("FAIL full_we_%0d: got %b want %b", i, bus.imem_we, (i < 4)); else pass++;
         if (i == 3) begin
            total++; if ({bus.imem_addr, bus.imem_wdata} !== {32'hC, 32'h2004_0004}) $display("FAIL full_last: got %h %h want 0000000c 20040004", bus.imem_addr, bus.imem_wdata); else pass++;
         end
      end
      bus.req_valid = 1'b0;
      step();
      total++; if ({err_full, count, bus.req_ready} !== {1'b1, 3'd4, 1'b0}) $display("FAIL full_state: got err_full=%b count=%0d ready=%b want 1 4 0", err_full, count, bus.req_ready); else pass++;
      total++; if (wr_cnt - wr0 !== 4) $display("FAIL full_writes: got %0d want 4", wr_cnt - wr0); else pass++;
      end_session();
   endtask

   task automatic test_illegal();
      begin_session(32'h0000_0080);
      req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      step();
      total++; if ({bus.imem_we, bus.imem_addr} !== {1'b1, 32'h80}) $display("FAIL ill_pre: got we=%b addr=%h want 1 00000080", bus.imem_we, bus.imem_addr); else pass++;
      req(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      step();
      total++; if ({bus.imem_we, err_kind} !== 2'b01) $display("FAIL ill_consume: got we,err_kind=%b want 01", {bus.imem_we, err_kind}); else pass++;
      req(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
      step();
      total++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 32'h84, 32'h0085_3022}) $display("FAIL ill_post: got we=%b addr=%h data=%h want 1 00000084 00853022", bus.imem_we, bus.imem_addr, bus.imem_wdata); else pass++;
      bus.req_valid = 1'b0;
      step();
      total++; if (count !== 3'd2) $display("FAIL ill_count: got %0d want 2", count); else pass++;
      end_session();
   endtask

   task automatic test_finish_same_cycle();
      begin_session(32'h0000_0300);
      req(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      step();
      req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      finish = 1'b1;
      step();
      finish = 1'b0;
      bus.req_valid = 1'b0;
      total++; if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 32'h300, 32'h0022_1820}) $display("FAIL fin_last_word: got we=%b addr=%h data=%h want 1 00000300 00221820", bus.imem_we, bus.imem_addr, bus.imem_wdata); else pass++;
      total++; if ({done, busy, bus.req_ready, err_kind} !== 4'b0101) $display("FAIL fin_draining: got done,busy,ready,err_kind=%b want 0101", {done, busy, bus.req_ready, err_kind}); else pass++;
      step();
      total++; if ({done, busy, bus.imem_we, count} !== {3'b100, 3'd1}) $display("FAIL fin_done: got done=%b busy=%b we=%b count=%0d want 1 0 0 1", done, busy, bus.imem_we, count); else pass++;
      begin_session(32'h0000_0400);
      total++; if ({count, err_kind, err_full, busy, done} !== {3'd0, 4'b0010}) $display("FAIL restart_clear: got count=%0d err_kind=%b err_full=%b busy=%b done=%b want 0 0 0 1 0", count, err_kind, err_full, busy, done); else pass++;
   endtask

   task automatic test_reset_mid();
      req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      step();
      total++; if (bus.imem_we !== 1'b1) $display("FAIL mid_accept: got %b want 1", bus.imem_we); else pass++;
      req(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
      rst = 1'b1;
      step();
      total++; if ({bus.req_ready, bus.imem_we, busy, done, err_kind, err_full, count} !== 9'b0) $display("FAIL mid_reset_flags: got %b want 0", {bus.req_ready, bus.imem_we, busy, done, err_kind, err_full, count}); else pass++;
      total++; if ({bus.imem_addr, bus.imem_wdata} !== 64'h0) $display("FAIL mid_reset_bus: got %h %h want 0 0", bus.imem_addr, bus.imem_wdata); else pass++;
      rst = 1'b0;
      step();
      total++; if ({bus.imem_we, busy, bus.req_ready} !== 3'b000) $display("FAIL mid_idle: got we,busy,ready=%b want 000", {bus.imem_we, busy, bus.req_ready}); else pass++;
      bus.req_valid = 1'b0;
      finish = 1'b1;
      step();
      finish = 1'b0;
      total++; if ({done, busy} !== 2'b00) $display("FAIL idle_ignores_finish: got done,busy=%b want 00", {done, busy}); else pass++;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      finish = 1'b0;
      base_addr = '0;
      bus.req_valid = 1'b0;
      bus.req_kind = '0;
      bus.req_rs = '0;
      bus.req_rt = '0;
      bus.req_rd = '0;
      bus.req_imm = '0;
      bus.req_target = '0;
      test_reset();
      test_start_encode();
      test_itype_wrap();
      test_rtype();
      test_back_to_back_full();
      test_illegal();
      test_finish_same_cycle();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Instruction encoder and program loader: the write-side counterpart of the control decoder. It accepts symbolic instruction requests (kind plus register, immediate and target fields) over a valid/ready handshake and encodes each one into a 32-bit MIPS word. It writes the encoded words to consecutive word addresses of instruction memory. It sits between the testbench/boot loader and the imem write port, so encoded programs round-trip through the decoder.

## Interface
- `DEPTH`, default 64: maximum words written per load session.
- `AW`, default 32: imem byte-address width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a session; sampled only in IDLE.
- `base_addr`  in  AW  byte address of first word; bits [1:0] are ignored (treated as 0).
- `finish`  in  1  end the session; sampled only in LOAD.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both valid and ready are high at the edge.
- `req_kind`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10–15 are illegal.
- `req_rs`, `req_rt`, `req_rd`  in  5 each  register fields.
- `req_imm`  in  16  immediate/offset field.
- `req_target`  in  26  jump target field.
- `imem_we`  out  1  write strobe.
- `imem_addr`  out  AW  word-aligned byte address.
- `imem_wdata`  out  32  encoded instruction.
- `count`  out  $clog2(DEPTH+1)  words written this session.
- `busy`  out  1  high in LOAD.
- `done`  out  1  high in DONE.
- `err_kind`  out  1  sticky: an illegal kind was accepted.
- `err_full`  out  1  sticky: `req_valid` was asserted while the block was full.

## Operation
- FSM states: IDLE, LOAD, DONE.
- Reset puts the FSM in IDLE and clears every output to 0: `req_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `count`, `busy`, `done`, `err_kind`, `err_full`.
- **IDLE**
  - `start=1` → LOAD. On that edge: address ← `{base_addr[AW-1:2], 2'b00}`, `count` ← 0, both error flags cleared.
- **LOAD**
  - `req_ready` = !full, where full = (`count` + pending == DEPTH).
  - On an accepted legal request, the block encodes it and registers the result into the write stage.
  - **R-type** (ADD, SUB, AND, OR, SLT): word = {000000, rs, rt, rd, 00000, funct}. funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - **I-type**: word = {op, rs, rt, imm}. op values: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - **J**: word = {000010, target}.
  - An accepted illegal kind is consumed, sets `err_kind`, and produces no write and no count change.
  - `req_valid` while full: not accepted, sets `err_full`.
  - `finish=1` → DONE once no write is pending. A request accepted in the same cycle as `finish` is still written. `finish` takes priority over further acceptance from the next cycle on.
- **DONE**
  - `done=1`, `req_ready=0`.
  - `start=1` → LOAD with a fresh session; `count` and error flags clear as in IDLE.
- **Arithmetic**
  - Address advances by 4 after each write and wraps modulo 2^AW without flagging.
  - `count` saturates at DEPTH; full blocks acceptance before overflow.
- **Mid-operation reset**: `rst` in any state aborts the session. No write is issued on the cycle after the reset edge.

## Timing
- Request accepted at edge k → `imem_we=1` with `imem_addr`/`imem_wdata` valid for exactly cycle k+1. `count` increments at edge k+1.
- Back-to-back acceptance sustains one write per cycle.
- `imem_addr` and `imem_wdata` hold their last value when `imem_we=0`.
- `busy`/`done` change on the edge of the state transition.
- `start` → first possible acceptance on the following cycle.

## Structure
- Shared package `mips_pkg` holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct localparams: F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - the `req_kind` enum;
  - the FSM state enum.
- The decoders use the same constants.
- One sub-module, `instr_encode`: purely combinational mapping from kind/fields to {word, legal}. The top level holds the FSM, write stage, address and count registers.

## Test plan
- Reset then `start`, base 0x0000_0040: ADD rs=1 rt=2 rd=3 → write addr 0x40, data 0x00221820. Next, LW rs=0 rt=8 imm=0x0004 → addr 0x44, data 0x8C080004. `count`=2.
- BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF. J target=0x0000010 → 0x08000010. ADDI rs=0 rt=9 imm=5 → 0x20090005. Results feed back through the controller and give branch=1, jump=1, alusrc=1 respectively.
- DEPTH=4, 6 back-to-back valid requests: 4 writes on consecutive cycles, `req_ready` drops after the 4th acceptance, `err_full`=1, `count`=4.
- `req_kind`=12 in a stream of legal kinds: no write, `err_kind`=1, addresses of surrounding writes stay contiguous.
- `finish` with acceptance in the same cycle: final word written, `done`=1 the cycle after. A new `start` clears `count` and `err_*`.
- `rst` asserted the cycle after an acceptance: no `imem_we` pulse, all outputs 0, FSM in IDLE.
